// File: rtl/mano_pkg.sv
// Shared widths, opcode encodings and timing-slot indices for the Mano
// basic-computer sequencing front end.
package mano_pkg;
  localparam int SC_W  = 3;
  localparam int OPC_W = 3;
  localparam int T_W   = 1 << SC_W;
  localparam int D_W   = 1 << OPC_W;

  typedef enum logic [OPC_W-1:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_RIO = 3'd7
  } opcode_e;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int T6 = 6;
  localparam int T7 = 7;

  // Run flip-flop S expressed as a two-state machine.
  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  function automatic opcode_e ir_opcode(input logic [15:0] ir);
    return opcode_e'(ir[14:12]);
  endfunction
endpackage

// File: rtl/mano_seq_ctrl_if.sv
// Control/observation bundle between the sequencer and its consumers.
interface mano_seq_ctrl_if;
  import mano_pkg::*;

  logic             start;
  logic             hlt;
  logic             sc_clr;
  logic [15:0]      ir;
  logic [T_W-1:0]   T;
  logic [D_W-1:0]   D;
  logic             I;
  logic             S;
  logic [SC_W-1:0]  sc;
  logic             sc_ovf;

  modport master (
    output start, hlt, sc_clr, ir,
    input  T, D, I, S, sc, sc_ovf
  );

  modport slave (
    input  start, hlt, sc_clr, ir,
    output T, D, I, S, sc, sc_ovf
  );
endinterface

// File: rtl/mano_dec_n.sv
// Generic N-bit binary to 2**N one-hot decoder with enable.
module mano_dec_n #(
  parameter int N = 3
) (
  input  logic [N-1:0]      bin,
  input  logic              en,
  output logic [(1<<N)-1:0] onehot
);
  for (genvar i = 0; i < (1 << N); i++) begin : g_bit
    assign onehot[i] = en && (bin == N'(i));
  end
endmodule

// File: rtl/mano_seq_ctrl.sv
// Run flip-flop, sequence counter, timing vector and registered opcode
// decode for the Mano control unit.
module mano_seq_ctrl
  import mano_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mano_seq_ctrl_if.slave bus
);
  run_state_e      state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [D_W-1:0]  d_q, d_d, d_nxt;
  logic            i_q, i_d;
  logic            ovf_q, ovf_d;
  logic [T_W-1:0]  t_vec;
  logic            unused_ir;

  assign unused_ir = ^bus.ir[11:0];

  // Timing vector is purely combinational from S and SC.
  mano_dec_n #(.N(SC_W)) u_tdec (
    .bin    (sc_q),
    .en     (state_q == RUNNING),
    .onehot (t_vec)
  );

  // Opcode decode only produces a value while T2 is active.
  mano_dec_n #(.N(OPC_W)) u_ddec (
    .bin    (ir_opcode(bus.ir)),
    .en     (t_vec[T2]),
    .onehot (d_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HALTED;
      sc_q    <= '0;
      d_q     <= '0;
      i_q     <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      d_q     <= d_d;
      i_q     <= i_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    d_d     = d_q;
    i_d     = i_q;
    ovf_d   = ovf_q;

    if (t_vec[T2]) begin
      d_d = d_nxt;
      i_d = bus.ir[15];
    end

    // hlt dominates both the counter and the run flip-flop.
    if (bus.hlt) begin
      sc_d = '0;
    end else if (state_q == RUNNING) begin
      if (bus.sc_clr) begin
        sc_d = '0;
      end else begin
        sc_d = sc_q + SC_W'(1);
        if (sc_q == SC_W'(T_W - 1)) ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      HALTED:  if (bus.hlt) state_d = HALTED;
               else if (bus.start) state_d = RUNNING;
      RUNNING: if (bus.hlt) state_d = HALTED;
      default: state_d = HALTED;
    endcase
  end

  assign bus.T      = t_vec;
  assign bus.D      = d_q;
  assign bus.I      = i_q;
  assign bus.S      = (state_q == RUNNING);
  assign bus.sc     = sc_q;
  assign bus.sc_ovf = ovf_q;
endmodule
